m_dm_responder: RTL

- Data-memory responder on the far side of the M-stage store byte-enable path.
- Accepts one request at a time from the M stage. Write requests carry a 4-bit byte-enable with lane-positioned write data; read requests carry a load op.
- Writes: masked byte writes into internal word RAM. Reads: returns the addressed byte, half or word, sign- or zero-extended, after a configurable wait-state latency through a valid/ready handshake.

---
 rtl/m_dm_responder_pkg.sv | 44 ++++
 rtl/m_dm_responder_if.sv | 34 +++
 rtl/m_load_ext.sv | 50 +++++
 rtl/m_dm_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/m_dm_responder_pkg.sv
// m_dm_responder_pkg
//   Shared definitions for the data-memory responder:
//   - state_e      : responder FSM state encoding (IDLE / BUSY / RESP)
//   - LD_*         : load-op codes carried on req_ld_op
//   - BE_*         : the only byte-enable patterns a store may use
//   - be_legal()   : store byte-enable legality + alignment check
package m_dm_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LW  = 3'd5;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // A store is legal only when its lane mask is one of the natural
    // byte/half/word masks and sits at the lanes addressed by off.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
        case (be)
            BE_B0:   return off == 2'd0;
            BE_B1:   return off == 2'd1;
            BE_B2:   return off == 2'd2;
            BE_B3:   return off == 2'd3;
            BE_H0:   return off == 2'd0;
            BE_H1:   return off == 2'd2;
            BE_W:    return off == 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/m_dm_responder_if.sv
// m_dm_responder_if
//   Request/response bus between the M stage (master) and the data-memory
//   responder (slave).
//   Request : req_valid, req_ready, req_addr, req_byteen, req_wdata, req_ld_op
//   Response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both high. A source holds valid and its payload stable until
//   that edge; ready may be high while valid is low, which means nothing.
interface m_dm_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic [2:0]  req_ld_op;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_byteen, req_wdata, req_ld_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_byteen, req_wdata, req_ld_op, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/m_load_ext.sv
// m_load_ext
//   Combinational load extractor: picks the byte/half/word selected by off
//   out of a 32-bit RAM word and sign- or zero-extends it per ld_op.
//   Ports:
//     word     in  32  RAM word
//     off      in  2   byte offset (addr[1:0])
//     ld_op    in  3   load op code (LD_*)
//     data     out 32  extended load data (0 for illegal ops)
//     misalign out 1   half not on even byte / word not on word boundary
//     illegal  out 1   ld_op is not a defined load
module m_load_ext
    import m_dm_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_op,
    output logic [31:0] data,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{off, 3'b000} +: 8];
        sel_half = off[1] ? word[31:16] : word[15:0];
        data     = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (ld_op)
            LD_LB:  data = {{24{sel_byte[7]}}, sel_byte};
            LD_LBU: data = {24'b0, sel_byte};
            LD_LH: begin
                data     = {{16{sel_half[15]}}, sel_half};
                misalign = off[0];
            end
            LD_LHU: begin
                data     = {16'b0, sel_half};
                misalign = off[0];
            end
            LD_LW: begin
                data     = word;
                misalign = (off != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/m_dm_responder.sv
// m_dm_responder
//   Data-memory responder behind the M-stage store byte-enable path.
//   One request in flight: IDLE accepts, BUSY burns WAIT_CYCLES wait states,
//   RESP holds the response until the consumer takes it. Stores are masked
//   byte writes into a word RAM; loads return extended byte/half/word data.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous, active-high reset
//     bus        slave modport of m_dm_responder_if (request + response)
//     dbg_state  out  current FSM state
//   Optional: define M_DM_WRITE_TRACE_EN to print one line per committed
//   write (time, word-aligned byte address, resulting word).
module m_dm_responder
    import m_dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    m_dm_responder_if.slave       bus,
    output state_e                dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    state_e        state, state_nxt;
    logic [CW-1:0] cnt;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  byteen_q;
    logic [2:0]  ld_op_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_byteen;
    logic [2:0]  e_ld_op;
    logic [31:0] rd_word, wr_word, ext_data;
    logic        ext_misalign, ext_illegal;
    logic        oor, is_write, e_err, resp_entry, commit_wr;

    // With WAIT_CYCLES=0 the RESP-entry edge is also the accept edge, so the
    // evaluation must see the live request rather than the latched copy.
    always_comb begin
        if (state == ST_IDLE) begin
            e_addr   = bus.req_addr;
            e_wdata  = bus.req_wdata;
            e_byteen = bus.req_byteen;
            e_ld_op  = bus.req_ld_op;
        end else begin
            e_addr   = addr_q;
            e_wdata  = wdata_q;
            e_byteen = byteen_q;
            e_ld_op  = ld_op_q;
        end
    end

    assign rd_word = mem[e_addr[2 +: AW]];

    m_load_ext u_load_ext (
        .word     (rd_word),
        .off      (e_addr[1:0]),
        .ld_op    (e_ld_op),
        .data     (ext_data),
        .misalign (ext_misalign),
        .illegal  (ext_illegal)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = e_byteen[i] ? e_wdata[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    assign is_write   = |e_byteen;
    assign oor        = {1'b0, e_addr} >= ADDR_LIMIT;
    assign e_err      = oor | (is_write ? !be_legal(e_byteen, e_addr[1:0])
                                        : (ext_misalign | ext_illegal));
    assign resp_entry = (state != ST_RESP) && (state_nxt == ST_RESP);
    // Reset gating keeps a held-in-reset accept from writing the RAM.
    assign commit_wr  = resp_entry && is_write && !e_err && !reset;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.req_valid) state_nxt = (WAIT_CYCLES > 0) ? ST_BUSY : ST_RESP;
            ST_BUSY: if (cnt == '0)     state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.req_ready = (state == ST_IDLE);
        bus.rsp_valid = (state == ST_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        dbg_state     = state;
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            ld_op_q  <= '0;
            cnt      <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                byteen_q <= bus.req_byteen;
                ld_op_q  <= bus.req_ld_op;
                cnt      <= CNT_INIT;
            end else if (state == ST_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (resp_entry) begin
                err_q   <= e_err;
                rdata_q <= (is_write || e_err) ? 32'h0 : ext_data;
            end
        end
    end

    // RAM is deliberately not reset; earlier committed writes survive reset.
    always_ff @(posedge clk) begin
        if (commit_wr) mem[e_addr[2 +: AW]] <= wr_word;
    end

`ifdef M_DM_WRITE_TRACE_EN
    always_ff @(posedge clk) begin
        if (commit_wr) $display("%0t dm_write addr=%08h data=%08h", $time, {e_addr[31:2], 2'b00}, wr_word);
    end
`else
`endif

endmodule
